// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, opcode defaults and the
// jump-target / branch-offset formation reused by later decode stages.
package fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        ISSUE = ST_ISSUE,
        FAULT = ST_FAULT
    } fetch_state_t;

    localparam logic [5:0] OP_J_DEF   = 6'h02;
    localparam logic [5:0] OP_BEQ_DEF = 6'h04;

    // Pseudo-direct jump: upper PC nibble, 26-bit word index, word aligned.
    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [31:0] word);
        return {pc_hi, word[25:0], 2'b00};
    endfunction

    function automatic logic signed [31:0] branch_offset(input logic [31:0] word);
        logic signed [31:0] imm_ext;
        imm_ext = {{16{word[15]}}, word[15:0]};
        return imm_ext <<< 2;
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational decode of the held instruction into raw redirect requests;
// the fetch FSM qualifies the raw flags with its issue state.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter logic [5:0] OP_J   = OP_J_DEF,
    parameter logic [5:0] OP_BEQ = OP_BEQ_DEF
) (
    input  logic [31:0] instr,
    input  logic [3:0]  pcHi,
    output logic        jmpFlag_raw,
    output logic        branchFlag_raw,
    output logic [31:0] jmpAddress,
    output logic [31:0] branchOffset
);

    logic [5:0] opcode;

    assign opcode         = instr[31:26];
    assign jmpFlag_raw    = (opcode == OP_J);
    assign branchFlag_raw = (opcode == OP_BEQ);
    assign jmpAddress     = jump_target(pcHi, instr);
    assign branchOffset   = branch_offset(instr);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: variable-latency imem handshake, instruction
// register, and one PC advance (sequential, jump or branch) per fetched word.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int         TIMEOUT = 16,
    parameter logic [5:0] OP_J    = OP_J_DEF,
    parameter logic [5:0] OP_BEQ  = OP_BEQ_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcIn,
    output logic        pcHold,
    output logic        jmpFlag,
    output logic [31:0] jmpAddress,
    output logic        branchFlag,
    output logic [31:0] branchOffset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic        fetchFault
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fetch_state_t     state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [31:0]      instr_nxt;
    logic             aligned;
    logic             jmp_raw, br_raw;

    assign aligned  = (pcIn[1:0] == 2'b00);
    assign imemAddr = pcIn;

    fetch_decode #(
        .OP_J   (OP_J),
        .OP_BEQ (OP_BEQ)
    ) u_decode (
        .instr          (instr),
        .pcHi           (pcIn[31:28]),
        .jmpFlag_raw    (jmp_raw),
        .branchFlag_raw (br_raw),
        .jmpAddress     (jmpAddress),
        .branchOffset   (branchOffset)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            instr    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            instr    <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        instr_nxt    = instr;
        pcHold       = 1'b1;
        imemReq      = 1'b0;
        instrValid   = 1'b0;
        fetchFault   = 1'b0;
        jmpFlag      = 1'b0;
        branchFlag   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (!aligned) begin
                    state_nxt = FAULT;
                end else begin
                    imemReq = 1'b1;
                    if (imemAck) begin
                        instr_nxt    = imemData;
                        wait_cnt_nxt = '0;
                        state_nxt    = ISSUE;
                    end else begin
                        // An ack in the last allowed cycle is taken above, so
                        // faulting only happens once TIMEOUT cycles went unanswered.
                        if (wait_cnt != CNT_MAX)
                            wait_cnt_nxt = wait_cnt + 1'b1;
                        if (wait_cnt_nxt == CNT_MAX)
                            state_nxt = FAULT;
                    end
                end
            end
            ISSUE: begin
                pcHold     = 1'b0;
                instrValid = 1'b1;
                jmpFlag    = jmp_raw;
                branchFlag = br_raw;
                state_nxt  = REQ;
            end
            FAULT: fetchFault = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed corner cases plus a randomized instruction
// stream whose PC is advanced by a behavioural model of the PC register.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcIn;
    logic        pcHold;
    logic        jmpFlag;
    logic [31:0] jmpAddress;
    logic        branchFlag;
    logic [31:0] branchOffset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic        instrValid;
    logic        fetchFault;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_instr;

    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcIn         (pcIn),
        .pcHold       (pcHold),
        .jmpFlag      (jmpFlag),
        .jmpAddress   (jmpAddress),
        .branchFlag   (branchFlag),
        .branchOffset (branchOffset),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instr        (instr),
        .instrValid   (instrValid),
        .fetchFault   (fetchFault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_jaddr(input logic [31:0] pc, input logic [31:0] w);
        return (pc & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    endfunction

    function automatic int model_boff(input logic [31:0] w);
        int imm;
        imm = int'(w & 32'h0000_FFFF);
        if (imm >= 32768) imm = imm - 65536;
        return imm * 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one time unit after the edge that starts a REQ cycle.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] word,
                         input int waits, input bit stray);
        logic exp_j, exp_b;
        pcIn     = pc;
        imemAck  = (waits == 0);
        imemData = (waits == 0) ? word : $urandom;
        #1;
        check("instr_keep", instr, last_instr);
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) begin
                imemAck  = (i == waits);
                imemData = (i == waits) ? word : $urandom;
                #1;
            end
            check("req", imemReq, 1);
            check("addr", imemAddr, pc);
            check("hold_req", pcHold, 1);
            check("valid_req", instrValid, 0);
            check("flags_req", {jmpFlag, branchFlag}, 0);
            tick();
        end
        imemAck  = stray;
        imemData = ~word;
        #1;
        exp_j = ((word >> 26) == 32'h02);
        exp_b = ((word >> 26) == 32'h04);
        check("valid_issue", instrValid, 1);
        check("hold_issue", pcHold, 0);
        check("req_issue", imemReq, 0);
        check("instr", instr, word);
        check("jmpFlag", jmpFlag, exp_j);
        check("branchFlag", branchFlag, exp_b);
        check("jmpAddress", jmpAddress, model_jaddr(pc, word));
        check("branchOffset", branchOffset, model_boff(word));
        last_instr = word;
        imemAck = 1'b0;
        tick();
    endtask

    // Asynchronous reset pulse started between edges, with a late ack pending.
    task automatic reset_pulse();
        rst     = 1'b1;
        imemAck = 1'b1;
        #1;
        check("rst_req", imemReq, 0);
        check("rst_hold", pcHold, 1);
        check("rst_fault", fetchFault, 0);
        check("rst_valid", instrValid, 0);
        tick();
        check("rst_instr", instr, 0);
        rst     = 1'b0;
        imemAck = 1'b0;
        #1;
        check("idle_req", imemReq, 0);
        check("idle_hold", pcHold, 1);
        last_instr = '0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, word;
        int          kind;
        rst        = 1'b1;
        pcIn       = '0;
        imemAck    = 1'b0;
        imemData   = '0;
        last_instr = '0;
        #3;
        check("reset_hold", pcHold, 1);
        check("reset_req", imemReq, 0);
        check("reset_valid", instrValid, 0);
        check("reset_fault", fetchFault, 0);
        check("reset_flags", {jmpFlag, branchFlag}, 0);
        check("reset_instr", instr, 0);

        @(posedge clk);
        #1;
        rst      = 1'b0;
        imemAck  = 1'b1;
        imemData = 32'hDEAD_BEEF;
        #1;
        check("idle_req0", imemReq, 0);
        check("idle_hold0", pcHold, 1);
        tick();

        fetch(32'h0000_0000, 32'h2002_0001, 0, 1'b0);
        fetch(32'h0000_0010, 32'h0800_0D03, 0, 1'b1);
        check("jmp_one_cycle", jmpFlag, 0);
        fetch(32'h0000_0014, 32'h1000_FFFD, 0, 1'b0);
        fetch(32'h0000_0018, 32'h2002_0001, 3, 1'b1);
        fetch(32'h0000_001C, 32'h0000_0000, 15, 1'b0);

        pc = 32'h0000_0100;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            word = $urandom;
            if (kind == 0)
                word = (word & 32'h03FF_FFFF) | (32'h02 << 26);
            else if (kind == 1)
                word = (word & 32'h03FF_FFFF) | (32'h04 << 26);
            else if (((word >> 26) == 32'h02) || ((word >> 26) == 32'h04))
                word = word ^ 32'h8000_0000;
            fetch(pc, word, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            if ((word >> 26) == 32'h02)
                pc = model_jaddr(pc, word);
            else if (((word >> 26) == 32'h04) && ($urandom_range(0, 1) == 1))
                pc = pc + 32'd4 + model_boff(word);
            else
                pc = pc + 32'd4;
        end

        pcIn    = 32'h0000_0200;
        imemAck = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_req", imemReq, 1);
            check("to_fault_early", fetchFault, 0);
            tick();
        end
        #1;
        check("to_fault", fetchFault, 1);
        check("to_req_off", imemReq, 0);
        check("to_hold", pcHold, 1);
        imemAck = 1'b1;
        tick();
        check("fault_sticky", fetchFault, 1);
        check("fault_valid", instrValid, 0);
        reset_pulse();

        pcIn    = 32'h0000_0006;
        imemAck = 1'b0;
        #1;
        check("mis_req", imemReq, 0);
        tick();
        check("mis_fault", fetchFault, 1);
        check("mis_req_off", imemReq, 0);
        check("mis_hold", pcHold, 1);
        reset_pulse();

        pcIn    = 32'h0000_0040;
        imemAck = 1'b0;
        #1;
        check("mid_req_before", imemReq, 1);
        #1;
        reset_pulse();
        fetch(32'h0000_0040, 32'h1000_0002, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller that drives the program counter's control side. It reads the current PC value and fetches the instruction word from instruction memory over a variable-latency req/ack handshake, then holds it in an instruction register. It decodes `j` and `beq`, and issues jmpFlag/jmpAddress/branchFlag/branchOffset to the PC with a hold signal, so the PC advances exactly once per fetched instruction. It sits between the PC and instruction memory, feeding the decode/execute path.

## Interface
- `TIMEOUT`, default 16: maximum cycles REQ waits for imemAck before faulting (≥1).
- `OP_J`, default 6'h02: jump opcode.
- `OP_BEQ`, default 6'h04: branch-if-equal opcode.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pcIn` in 32: current PC value (byte address).
- `pcHold` out 1: 1 = PC must not update this edge.
- `jmpFlag` out 1: jump redirect, valid only while pcHold=0.
- `jmpAddress` out 32: jump target.
- `branchFlag` out 1: conditional branch request; the PC qualifies it with the ALU zeroflag.
- `branchOffset` out 32: signed byte offset relative to PC+4.
- `imemReq` out 1: fetch request.
- `imemAddr` out 32: fetch address.
- `imemAck` in 1: data valid on imemData this cycle.
- `imemData` in 32: instruction word.
- `instr` out 32: instruction register.
- `instrValid` out 1: one-cycle strobe that instr is new.
- `fetchFault` out 1: sticky fault (timeout or misaligned PC).

## Operation
- States: IDLE, REQ, ISSUE, FAULT.
- IDLE: reset state. Moves to REQ after one cycle.
- REQ:
  - If pcIn[1:0]≠0, go to FAULT and do not assert imemReq.
  - Otherwise imemReq=1 and imemAddr=pcIn, held stable until ack.
  - On imemAck=1: capture imemData into instr, clear the wait counter, go to ISSUE.
  - If the wait counter reaches TIMEOUT without ack, go to FAULT.
- ISSUE (exactly one cycle): pcHold=0, instrValid=1. Decode opcode = instr[31:26]:
  - OP_J: jmpFlag=1; jmpAddress = {pcIn[31:28], instr[25:0], 2'b00}.
  - OP_BEQ: branchFlag=1; branchOffset = sign-extend(instr[15:0]) << 2.
  - Anything else: both flags 0 (sequential PC+4).
  - Next state is REQ.
- FAULT: fetchFault=1, pcHold=1, imemReq=0. Only rst exits FAULT.
- Outputs are combinational from state and instr.
  - jmpFlag and branchFlag are 0 in every state except ISSUE.
  - jmpAddress and branchOffset are always driven from instr, so they are harmless when the flags are 0.
- imemAck outside REQ is ignored.
- Wait counter width is clog2(TIMEOUT+1). It counts only in REQ and saturates.

## Timing
- Reset values (asserted asynchronously): state=IDLE, instr=0, counter=0. Resulting outputs: pcHold=1, all flags 0, imemReq=0, instrValid=0, fetchFault=0.
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction, i.e. REQ then ISSUE.
- N wait cycles before ack: N+2 cycles per instruction.
- The PC updates at the rising edge that ends ISSUE. A new pcIn is therefore visible in the next REQ cycle.
- First imemReq appears in the 2nd cycle after rst deasserts (IDLE, then REQ).
- Ack on exactly the TIMEOUT-th wait cycle: the ack wins and the FSM goes to ISSUE.
- rst asserted mid-REQ: imemReq drops immediately, not at the next edge. A late ack is ignored.

## Structure
- Shared package `fetch_pkg`: state encoding (2-bit localparams), OP_J/OP_BEQ defaults, the jump-target and branch-offset formation as functions. The functions are reused by the later decode stage.
- Sub-module `fetch_decode` (combinational): instr + pcIn[31:28] → jmpFlag_raw, branchFlag_raw, jmpAddress, branchOffset. The FSM gates the raw flags with ISSUE.

## Test plan
- Reset then zero-wait memory returning 32'h2002_0001 (non-branch) at pcIn=0:
  - imemReq first high in cycle 2, imemAddr=0.
  - ISSUE in cycle 3 with flags 0, pcHold=0, instr=32'h2002_0001.
- Jump: imemData=32'h0800_0D03 at pcIn=32'h0000_0010 → jmpFlag=1, jmpAddress=32'h0000_340C for exactly one cycle.
- Branch: imemData=32'h1000_FFFD → branchFlag=1, branchOffset=-12 (32'hFFFF_FFF4).
- Wait states and timeout:
  - Ack after 3 wait cycles → ISSUE in the 5th cycle after REQ entry, imemAddr stable throughout.
  - No ack for TIMEOUT=16 cycles → fetchFault=1, imemReq=0, pcHold=1.
  - Ack on cycle 16 exactly → normal ISSUE.
- Misaligned PC: pcIn=32'h0000_0006 → FAULT with no imemReq pulse. A stray imemAck in IDLE/ISSUE is ignored.
- Async rst pulse mid-REQ (between clock edges) → imemReq and state clear immediately. After release, the fetch restarts from IDLE.
